core_if_istr_fifo: RTL and testbench

//  Instruction buffer between the fetch stage and the ID stage (the istr decoder).

---
 rtl/core_if_istr_fifo_pkg.sv | 14 +
 rtl/core_if_istr_fifo.sv | 103 ++++++++++
 tb/tb_core_if_istr_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/core_if_istr_fifo_pkg.sv
// Shared types for the fetch -> ID instruction buffer.
package core_if_istr_fifo_pkg;

    // One fetched word as it travels from fetch to the decoder.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] istr;
        logic        err;
    } if_istr_entry_t;

    // addi x0, x0, 0 -- what the decoder sees when nothing is valid.
    localparam logic [31:0] ISTR_NOP = 32'h00000013;

endpackage

// File: rtl/core_if_istr_fifo.sv
// Instruction buffer between fetch and ID: a DEPTH-entry FIFO of {pc, istr, err}.
// Head entry is read straight out of the array (no output register).
// Optional macro ISTR_FIFO_BYPASS_EN: when the buffer is empty, a pushed word is
// forwarded to ID in the same cycle and skips the array if ID takes it at once.
module core_if_istr_fifo
    import core_if_istr_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rest,
    input  logic                     flush,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              if_istr,
    input  logic                     if_err,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_istr,
    output logic                     id_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if_istr_entry_t mem [DEPTH];
    if_istr_entry_t head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic push;
    logic pop;
    logic byp;
    logic stored_vld;
    logic wr_en;
    logic rd_adv;

    // Full blocks intake even if ID pops this cycle, so id_ready never reaches if_ready.
    assign if_ready   = rest && !flush && (count != CW'(DEPTH));
    assign push       = if_valid && if_ready;
    assign stored_vld = rest && !flush && (count != '0);

`ifdef ISTR_FIFO_BYPASS_EN
    assign byp = push && (count == '0);
`else
    assign byp = 1'b0;
`endif

    assign id_valid = stored_vld || byp;
    assign pop      = id_valid && id_ready;
    // A bypassed word consumed immediately never touches the array or pointers.
    assign wr_en    = push && !(byp && id_ready);
    assign rd_adv   = pop && !byp;
    assign head     = mem[rd_ptr];

    // Payload storage; deliberately not reset, only written on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{pc: if_pc, istr: if_istr, err: if_err};
        end
    end

    // Pointers and occupancy; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (!rest) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_adv})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output mux: bypass word, else stored head, else a harmless NOP.
    always_comb begin
        id_pc   = '0;
        id_istr = ISTR_NOP;
        id_err  = 1'b0;
        if (byp) begin
            id_pc   = if_pc;
            id_istr = if_istr;
            id_err  = if_err;
        end else if (stored_vld) begin
            id_pc   = head.pc;
            id_istr = head.istr;
            id_err  = head.err;
        end
    end

endmodule

// File: tb/tb_core_if_istr_fifo.sv
// Self-checking bench for core_if_istr_fifo: directed table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_core_if_istr_fifo;
    import core_if_istr_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] istr;
        logic        err;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] istr;
        logic        er;
        logic        rdy;
        logic        e_idv;
        logic        e_ifr;
        int          e_cnt;
        logic [31:0] e_istr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rest, flush, if_valid, if_ready, if_err;
    logic [31:0]   if_pc, if_istr;
    logic          id_valid, id_ready, id_err;
    logic [31:0]   id_pc, id_istr;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    core_if_istr_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rest(rest), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_istr(if_istr), .if_err(if_err),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_istr(id_istr), .id_err(id_err),
        .count(count)
    );

    ent_t q[$];
    int   vec_cnt = 0;
    int   mis_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %h expected %h (vector %0d)", nm, act, exp, vec_cnt);
        end
    endtask

    function automatic vec_t tv(input logic r, f, v, input logic [31:0] pc, istr,
                                input logic e, rd, eidv, eifr, input int ecnt,
                                input logic [31:0] eistr);
        vec_t t;
        t.rst = r; t.fl = f; t.iv = v; t.pc = pc; t.istr = istr; t.er = e; t.rdy = rd;
        t.e_idv = eidv; t.e_ifr = eifr; t.e_cnt = ecnt; t.e_istr = eistr;
        return t;
    endfunction

    // Apply one cycle; always compare against the model, and against the
    // vector's hand-written expectations when tab is set.
    task automatic step(input vec_t t, input bit tab);
        logic m_ifr, m_idv;
        ent_t h;
        rest = t.rst; flush = t.fl; if_valid = t.iv; if_pc = t.pc;
        if_istr = t.istr; if_err = t.er; id_ready = t.rdy;
        @(negedge clk);
        m_ifr = t.rst && !t.fl && (q.size() != DEPTH);
        m_idv = t.rst && !t.fl && (q.size() != 0);
        h.pc = '0; h.istr = ISTR_NOP; h.err = 1'b0;
        if (q.size() != 0) h = q[0];
`ifdef ISTR_FIFO_BYPASS_EN
        if (q.size() == 0 && t.iv && m_ifr) begin
            m_idv = 1'b1;
            h.pc = t.pc; h.istr = t.istr; h.err = t.er;
        end
`endif
        if (!m_idv) begin
            h.pc = '0; h.istr = ISTR_NOP; h.err = 1'b0;
        end
        vec_cnt++;
        chk("if_ready", 32'(if_ready), 32'(m_ifr));
        chk("id_valid", 32'(id_valid), 32'(m_idv));
        chk("count",    32'(count),    32'(q.size()));
        chk("id_pc",    id_pc,         h.pc);
        chk("id_istr",  id_istr,       h.istr);
        chk("id_err",   32'(id_err),   32'(h.err));
        if (tab) begin
            chk("tab_id_valid", 32'(id_valid), 32'(t.e_idv));
            chk("tab_if_ready", 32'(if_ready), 32'(t.e_ifr));
            chk("tab_count",    32'(count),    32'(t.e_cnt));
            chk("tab_id_istr",  id_istr,       t.e_istr);
        end
        @(posedge clk);
        if (!t.rst || t.fl) q.delete();
        else begin
            if (t.iv && m_ifr) q.push_back('{pc: t.pc, istr: t.istr, err: t.er});
            if (m_idv && t.rdy) void'(q.pop_front());
        end
        #1;
    endtask

    vec_t tab[16];

    initial begin
        // Reset test 1, then fill/drain test 2 (base-build latency).
        tab[0]  = tv(0,0,0, 32'h0, 32'h0,        0,0, 0,0,0, ISTR_NOP);
        tab[1]  = tv(0,0,0, 32'h0, 32'h0,        0,0, 0,0,0, ISTR_NOP);
        tab[2]  = tv(1,0,1, 32'h0, 32'h00500093, 0,1, 0,1,0, ISTR_NOP);
        tab[3]  = tv(1,0,1, 32'h4, 32'h00108133, 0,1, 1,1,1, 32'h00500093);
        tab[4]  = tv(1,0,0, 32'h0, 32'h0,        0,1, 1,1,1, 32'h00108133);
        tab[5]  = tv(1,0,0, 32'h0, 32'h0,        0,0, 0,1,0, ISTR_NOP);
        tab[6]  = tv(1,0,1, 32'h100, 32'hA0,     0,0, 0,1,0, ISTR_NOP);
        tab[7]  = tv(1,0,1, 32'h104, 32'hA1,     0,0, 1,1,1, 32'hA0);
        tab[8]  = tv(1,0,1, 32'h108, 32'hA2,     0,0, 1,1,2, 32'hA0);
        tab[9]  = tv(1,0,1, 32'h10C, 32'hA3,     0,0, 1,1,3, 32'hA0);
        tab[10] = tv(1,0,1, 32'h110, 32'hA4,     0,0, 1,0,4, 32'hA0);
        tab[11] = tv(1,0,0, 32'h0, 32'h0,        0,1, 1,0,4, 32'hA0);
        tab[12] = tv(1,0,0, 32'h0, 32'h0,        0,1, 1,1,3, 32'hA1);
        tab[13] = tv(1,0,0, 32'h0, 32'h0,        0,1, 1,1,2, 32'hA2);
        tab[14] = tv(1,0,0, 32'h0, 32'h0,        0,1, 1,1,1, 32'hA3);
        tab[15] = tv(1,0,0, 32'h0, 32'h0,        0,1, 0,1,0, ISTR_NOP);

        rest = 0; flush = 0; if_valid = 0; if_pc = '0; if_istr = '0; if_err = 0; id_ready = 0;
        @(posedge clk); #1;

`ifndef ISTR_FIFO_BYPASS_EN
        for (int i = 0; i < 16; i++) step(tab[i], 1'b1);

        // Push/pop at count==2 keeps count steady and wraps the pointers.
        step(tv(1,0,1, 32'h200, 32'hB0000000, 0,0, 0,0,0,0), 1'b0);
        step(tv(1,0,1, 32'h204, 32'hB0000001, 0,0, 0,0,0,0), 1'b0);
        for (int k = 0; k < 10; k++)
            step(tv(1,0,1, 32'h208 + 4*k, 32'hB0000002 + k, 0,1, 1,1,2, 32'hB0000000 + k), 1'b1);
        step(tv(1,0,0, 0, 0, 0,1, 0,0,0,0), 1'b0);
        step(tv(1,0,0, 0, 0, 0,1, 0,0,0,0), 1'b0);

        // Flush with three queued plus a push in the flush cycle.
        for (int k = 0; k < 3; k++)
            step(tv(1,0,1, 32'h300 + 4*k, 32'hC0 + k, 0,0, 0,0,0,0), 1'b0);
        step(tv(1,1,1, 32'h400, 32'hD0, 0,0, 0,0,3, ISTR_NOP), 1'b1);
        step(tv(1,0,1, 32'h404, 32'hD1, 0,0, 0,1,0, ISTR_NOP), 1'b1);
        step(tv(1,0,0, 0, 0, 0,1, 1,1,1, 32'hD1), 1'b1);
        chk("flush_pc", id_pc, 32'h0);
`else
        // Same-cycle bypass: consumed without storage, then stored when ID stalls.
        step(tv(1,0,1, 32'h500, 32'hF0, 0,1, 1,1,0, 32'hF0), 1'b1);
        step(tv(1,0,1, 32'h504, 32'hF1, 0,0, 1,1,0, 32'hF1), 1'b1);
        step(tv(1,0,0, 0, 0, 0,0, 1,1,1, 32'hF1), 1'b1);
        step(tv(1,0,0, 0, 0, 0,1, 1,1,1, 32'hF1), 1'b1);
`endif

        // Error tag on a single entry; neighbours stay clean.
        step(tv(1,0,1, 32'h600, 32'hE0,       0,1, 0,0,0,0), 1'b0);
        step(tv(1,0,1, 32'h604, 32'hFFFFFFFF, 1,1, 0,0,0,0), 1'b0);
        step(tv(1,0,1, 32'h608, 32'hE2,       0,1, 0,0,0,0), 1'b0);
        step(tv(1,0,0, 0, 0, 0,1, 0,0,0,0), 1'b0);
        step(tv(1,0,0, 0, 0, 0,1, 0,0,0,0), 1'b0);

        // Random traffic including occasional reset and flush.
        for (int n = 0; n < 3000; n++) begin
            step(tv($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom),
                    $urandom_range(0, 2) != 0, 0,0,0,0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
